// File: rtl/mem_bist.sv
// ---------------------------------------------------------------------------
// mem_bist
//
// Built-in self-test initiator for the 2**ADDR_WIDTH x DATA_WIDTH synchronous
// memory. It acts as the master of the memory's strobe interface and runs two
// march phases back to back:
//   1. clear test:        write 0 to every address, then read every address
//                         back and expect 0.
//   2. data = address:    write addr (zero-extended) to every address, then
//                         read every address back and expect addr.
// Mismatches are counted over both phases. The address and data of the first
// mismatch are captured, and pass/fail is reported together with done.
//
// Ports
//   clk        rising-edge clock, shared with the memory
//   reset      asynchronous, active-high reset
//   start      launches a test when sampled high in IDLE or DONE
//   read       memory read strobe
//   write      memory write strobe
//   addr       memory address
//   data_in    write data to the memory
//   data_out   read data from the memory (registered by the memory)
//   busy       test in progress
//   done       test complete, held until the next accepted start or reset
//   pass       valid with done; 1 when err_count == 0
//   err_count  total mismatches over both phases (max 2*depth)
//   fail_addr  address of the first mismatch
//   fail_data  data read at the first mismatch
//   dbg_state  current FSM state encoding, for checkers and debug
//
// Memory strobe protocol (there is no back-pressure on this interface):
//   write=1/read=0 stores data_in at addr on the next clk edge; read=1/write=0
//   makes the memory register mem[addr] onto data_out on the next clk edge.
//   read and write are never high together. When both are low the memory is
//   idle and data_out holds its last value.
// ---------------------------------------------------------------------------
module mem_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  read,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR_WR = 3'd1,
      S_CLR_RD = 3'd2,
      S_DA_WR  = 3'd3,
      S_DA_RD  = 3'd4,
      S_DRAIN  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   state_t state;
   state_t state_nxt;

   // Next values of the registered outputs, produced by the output process.
   logic                  read_nxt;
   logic                  write_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] data_in_nxt;
   logic                  busy_nxt;
   logic                  done_nxt;
   logic                  pass_nxt;
   logic [ADDR_WIDTH+1:0] err_nxt;

   // Check pipeline: describes the read whose data the memory is registering
   // on the current edge, so the compare happens one edge later.
   logic                  chk_valid;
   logic [ADDR_WIDTH-1:0] chk_addr;
   logic [DATA_WIDTH-1:0] chk_exp;

   logic start_acc;
   logic in_phase;
   logic last_addr;
   logic mismatch;
   logic first_fail;

   assign dbg_state = state;

   // A start is only honoured when no test is running.
   assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

   assign in_phase  = (state == S_CLR_WR) || (state == S_CLR_RD) ||
                      (state == S_DA_WR)  || (state == S_DA_RD);

   // The address register doubles as the phase counter.
   assign last_addr = (addr == ADDR_LAST);

   assign mismatch   = chk_valid && (data_out != chk_exp);
   assign first_fail = mismatch && (err_count == '0);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_CLR_WR;
         S_CLR_WR: if (last_addr) state_nxt = S_CLR_RD;
         S_CLR_RD: if (last_addr) state_nxt = S_DA_WR;
         S_DA_WR:  if (last_addr) state_nxt = S_DA_RD;
         S_DA_RD:  if (last_addr) state_nxt = S_DRAIN;
         S_DRAIN:  state_nxt = S_DONE;
         S_DONE:   if (start) state_nxt = S_CLR_WR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: every output is registered, so this process computes
   // the value each output takes after the coming edge, keyed on the
   // state being entered.
   // ------------------------------------------------------------------
   always_comb begin
      write_nxt   = (state_nxt == S_CLR_WR) || (state_nxt == S_DA_WR);
      read_nxt    = (state_nxt == S_CLR_RD) || (state_nxt == S_DA_RD);
      busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      addr_nxt    = addr;
      data_in_nxt = data_in;

      if (start_acc) begin
         addr_nxt    = '0;
         data_in_nxt = '0;
      end else if (in_phase) begin
         // Natural wrap from ADDR_LAST to 0 lines up with the phase change.
         addr_nxt    = addr + 1'b1;
         data_in_nxt = (state_nxt == S_DA_WR) ? DATA_WIDTH'(addr_nxt) : '0;
      end

      if (start_acc) begin
         err_nxt = '0;
      end else begin
         err_nxt = err_count + (ADDR_WIDTH+2)'(mismatch);
      end

      // The last compare lands on the same edge that enters DONE, so pass
      // is derived from the already-updated count.
      done_nxt = (state_nxt == S_DONE);
      pass_nxt = done_nxt && (err_nxt == '0);
   end

   // ------------------------------------------------------------------
   // Output and check-pipeline registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read      <= 1'b0;
         write     <= 1'b0;
         addr      <= '0;
         data_in   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         chk_valid <= 1'b0;
         chk_addr  <= '0;
         chk_exp   <= '0;
      end else begin
         read      <= read_nxt;
         write     <= write_nxt;
         addr      <= addr_nxt;
         data_in   <= data_in_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_count <= err_nxt;

         // Tag the read being presented now; the memory registers its data
         // on this same edge.
         chk_valid <= read;
         chk_addr  <= addr;
         chk_exp   <= (state == S_DA_RD) ? DATA_WIDTH'(addr) : '0;

         if (start_acc) begin
            fail_addr <= '0;
            fail_data <= '0;
         end else if (first_fail) begin
            fail_addr <= chk_addr;
            fail_data <= data_out;
         end
      end
   end

endmodule

// File: doc/mem_bist.md
# mem_bist

Synthesizable built-in self-test initiator for the 32x8 synchronous memory (`mem`). It drives that memory's read/write strobe interface from the master side and runs two march phases: a clear test (write 0, read back 0) and a data = address test (write addr, read back addr). It counts mismatches and reports pass/fail. It sits beside the memory and replaces the behavioural bench as the source of memory traffic in silicon.

## Interface
- `ADDR_WIDTH`, default 5: memory address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: memory data width; must be >= ADDR_WIDTH.
- `clk`  in  1  rising-edge clock, shared with the memory.
- `reset`  in  1  asynchronous, active-high reset. One clock, no other reset.
- `start`  in  1  launches a test when sampled high in IDLE or DONE.
- `read`  out  1  memory read strobe.
- `write`  out  1  memory write strobe.
- `addr`  out  ADDR_WIDTH  memory address.
- `data_in`  out  DATA_WIDTH  write data to the memory.
- `data_out`  in  DATA_WIDTH  read data from the memory, registered by the memory on the clk edge where read=1 and write=0.
- `busy`  out  1  test in progress.
- `done`  out  1  test complete; held until the next start or reset.
- `pass`  out  1  valid with done; 1 when err_count == 0.
- `err_count`  out  ADDR_WIDTH+2  total mismatches over both phases (max 2*depth).
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `fail_data`  out  DATA_WIDTH  data read at the first mismatch.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states and transitions:
  - IDLE -> CLR_WR on start.
  - CLR_WR: depth cycles with write=1, read=0, addr 0..depth-1, data_in=0. -> CLR_RD.
  - CLR_RD: depth cycles with read=1, write=0, addr 0..depth-1, data_in=0. -> DA_WR.
  - DA_WR: as CLR_WR, but data_in = addr zero-extended. -> DA_RD.
  - DA_RD: as CLR_RD; expected data = addr. -> DRAIN.
  - DRAIN: one cycle, read=write=0. -> DONE.
  - DONE: done=1, busy=0. -> CLR_WR on start.
- An address counter increments by 1 each cycle inside a phase and wraps from depth-1 to 0 at the phase change.
- read and write are never both 1. Outside the W/R states both are 0, and addr/data_in hold their last value.
- Check pipeline:
  - Each read cycle loads `chk_valid`, `chk_addr`, `chk_exp` at the edge where the memory captures data_out.
  - On the following edge, if chk_valid and data_out !== chk_exp, err_count increments.
  - On the first such mismatch, fail_addr/fail_data load chk_addr/data_out.
- A start accepted from IDLE or DONE clears err_count, fail_addr, fail_data, done and pass, and sets busy.
- start while busy is ignored. start held high in DONE restarts the test.
- reset asserted at any point forces IDLE and zero outputs immediately, without waiting for clk. Memory contents are not touched. The next start runs a full test.

## Timing
- Edge P0 samples start=1. Registered outputs then appear as follows:
  - P0..P31: CLR_WR, addr k after edge P0+k.
  - P32..P63: CLR_RD.
  - P64..P95: DA_WR.
  - P96..P127: DA_RD.
  - P128: DRAIN.
  - P129: DONE, with done=1, pass valid, busy=0.
- busy is 1 from P0 to P128 inclusive.
- Read latency: addr k is presented after edge Pn, the memory registers data at Pn+1, and the compare result lands at Pn+2.
- The last read's compare (P129) coincides with entry to DONE. pass is computed from the updated count in the same edge.
- Writes after a read phase do not disturb pending compares, since data_out only updates when read=1.
- For a general depth D, done asserts at P(4D+1).

## Test plan
- Reset: assert reset mid-clock -> all outputs 0 before the next edge. Hold reset with start=1 -> outputs stay 0.
- Good memory: pulse start at P0 ->
  - busy at P0, done and pass=1 at P129, err_count=0;
  - monitor confirms read&write never both high, and the 128 accesses are in the stated order.
- Single bad location: bench memory returns 8'h01 for addr 7 on every read -> err_count=2, fail_addr=7, fail_data=8'h01, pass=0, done at P129.
- Stuck bit: data_out[7] forced to 1 -> err_count=64, fail_addr=0, fail_data=8'h80, pass=0.
- Reset mid-test: assert reset at P40 for 3 cycles, then start -> immediate IDLE and zeros, then a clean rerun finishing with pass=1 and err_count=0.
- Start handling:
  - start pulsed at P10 and P60 while busy -> ignored, done still at P129;
  - start after done with the faulty memory from the bad-location case -> counters cleared at the start edge, and the test reruns to err_count=2.
